// File: rtl/ibex_pkg.sv
// Shared types for the load-return path: access size encoding and assembler states.
package ibex_pkg;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_FIRST  = 2'd1,
        WAIT_SECOND = 2'd2
    } ld_state_e;

    // The unused encoding 3 is folded onto a full word access.
    function automatic ld_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return LD_BYTE;
            2'd1:    return LD_HALF;
            default: return LD_WORD;
        endcase
    endfunction

    function automatic logic needs_split(input logic [1:0] offset, input ld_size_e size);
        return ((size == LD_WORD) && (offset != 2'd0)) ||
               ((size == LD_HALF) && (offset == 2'd3));
    endfunction

endpackage

// File: rtl/ibex_load_align_ext.sv
// Truncates an already rotated/merged load word to the access size and
// zero- or sign-extends it to 32 bits.
module ibex_load_align_ext
    import ibex_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            LD_BYTE: data_o = {{24{sign_i & data_i[7]}}, data_i[7:0]};
            LD_HALF: data_o = {{16{sign_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/ibex_load_data_assembler.sv
// Collects one or two bus response words for a load, aligns and extends the
// requested bytes, and presents them as a single registered result pulse.
//
// state       | meaning
// IDLE        | ready for a new load descriptor
// WAIT_FIRST  | descriptor captured, waiting for the first response word
// WAIT_SECOND | misaligned load, low bytes held in rdata_q, waiting for the second word
module ibex_load_data_assembler
    import ibex_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter bit ErrSticky = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_offset_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sign_i,
    output logic        split_o,

    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_rdata_i,
    input  logic        rsp_err_i,

    output logic        out_valid_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o,
    output logic        busy_o
);

    if (DataWidth != 32) begin : g_width_check
        $error("ibex_load_data_assembler supports only DataWidth == 32");
    end

    ld_state_e   state_q, state_d;
    logic [1:0]  offset_q;
    ld_size_e    size_q;
    logic        sign_q;
    logic        split_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        out_valid_q;
    logic [31:0] out_rdata_q;
    logic        out_err_q;

    logic        req_accept;
    logic        rsp_first_split;
    logic        rsp_final;
    logic [63:0] rdata_dup;
    logic [31:0] rot_first;
    logic [31:0] shift_first;
    logic [2:0]  hi_bytes;
    logic [31:0] merged;
    logic [31:0] final_word;
    logic [31:0] ext_data;
    logic        err_final;

    assign req_accept      = (state_q == IDLE) && req_valid_i;
    assign rsp_first_split = (state_q == WAIT_FIRST) && rsp_valid_i && split_q;
    assign rsp_final       = rsp_valid_i &&
                             (((state_q == WAIT_FIRST) && !split_q) || (state_q == WAIT_SECOND));

    assign rdata_dup   = {rsp_rdata_i, rsp_rdata_i} >> {offset_q, 3'b000};
    assign rot_first   = rdata_dup[31:0];
    assign shift_first = rsp_rdata_i >> {offset_q, 3'b000};

    // The first word contributed 4-offset bytes; the second word fills in above them.
    assign hi_bytes   = 3'd4 - {1'b0, offset_q};
    assign merged     = rdata_q | (rsp_rdata_i << {hi_bytes, 3'b000});
    assign final_word = (state_q == WAIT_SECOND) ? merged : rot_first;

    assign err_final = ErrSticky ? (err_q | rsp_err_i) : rsp_err_i;

    ibex_load_align_ext u_align_ext (
        .data_i (final_word),
        .size_i (size_q),
        .sign_i (sign_q),
        .data_o (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (rsp_valid_i) state_d = split_q ? WAIT_SECOND : IDLE;
            end
            WAIT_SECOND: begin
                if (rsp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        split_o     = split_q && (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            offset_q    <= 2'd0;
            size_q      <= LD_BYTE;
            sign_q      <= 1'b0;
            split_q     <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= 32'd0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= rsp_final;
            if (req_accept) begin
                offset_q <= req_offset_i;
                size_q   <= decode_size(req_size_i);
                sign_q   <= req_sign_i;
                split_q  <= needs_split(req_offset_i, decode_size(req_size_i));
                rdata_q  <= 32'd0;
                err_q    <= 1'b0;
            end
            if (rsp_first_split) begin
                rdata_q <= shift_first;
                err_q   <= rsp_err_i;
            end
            if (rsp_final) begin
                out_rdata_q <= ext_data;
                out_err_q   <= err_final;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_rdata_o = out_rdata_q;
    assign out_err_o   = out_err_q;

    a_no_illegal_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_accept |-> (req_size_i != 2'd3));

    a_no_rsp_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> (state_q != IDLE));

    a_single_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_q |=> !out_valid_q);

    a_busy_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o == (state_q != IDLE));

endmodule
